// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-RAM arbiter: CPU port, DMA port and RAM side.
// The arbiter takes the slave view; the environment takes the master view.
interface dmem_arbiter_if #(
    parameter int DMEM_POWER = 18,
    parameter int WORD_W     = 32
);
    // CPU (MEM stage) port
    logic                  c_req;
    logic                  c_we;
    logic [WORD_W-1:0]     c_addr;
    logic [WORD_W-1:0]     c_wdata;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [WORD_W-1:0]     c_rdata;
    logic                  stallM;

    // Loader / DMA port
    logic                  d_req;
    logic                  d_we;
    logic [WORD_W-1:0]     d_addr;
    logic [WORD_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [WORD_W-1:0]     d_rdata;

    // Single-port RAM side
    logic                  mem_en;
    logic                  mem_we;
    logic [DMEM_POWER-1:0] mem_addr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [WORD_W-1:0]     mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, stallM,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, stallM,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU has fixed priority, DMA is forced ahead after
// MAX_WAIT consecutive refusals. One RAM access per cycle; read responses
// are routed back to their requester through a MEM_LAT-deep tag pipeline.
module dmem_arbiter #(
    parameter  int DMEM_POWER = 18,
    parameter  int MEM_LAT    = 2,
    parameter  int MAX_WAIT   = 4,
    localparam int WAIT_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus,
    output logic [1:0]        o_state,
    output logic [WAIT_W-1:0] o_wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [MEM_LAT-1:0]  r_tag_vld_p0;
    logic [MEM_LAT-1:0]  r_tag_dma_p0;
    logic [31:0]         r_c_rdata;
    logic [31:0]         r_d_rdata;

    logic                w_force_dma;
    logic                w_c_gnt;
    logic                w_d_gnt;
    logic                w_rd_issue;
    logic                w_c_rvalid;
    logic                w_d_rvalid;
    logic                w_unused;

    // Only the word-index bits of the byte addresses reach the RAM.
    assign w_unused = ^{bus.c_addr[1:0], bus.c_addr[31:DMEM_POWER+2],
                        bus.d_addr[1:0], bus.d_addr[31:DMEM_POWER+2]};

    // Grant: CPU first unless the DMA port has been refused MAX_WAIT times in a row.
    // Reset gates the grants so nothing reaches the RAM while reset is held.
    assign w_force_dma = bus.d_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_c_gnt     = reset && bus.c_req && !w_force_dma;
    assign w_d_gnt     = reset && bus.d_req && !w_c_gnt;
    assign w_rd_issue  = (w_c_gnt && !bus.c_we) || (w_d_gnt && !bus.d_we);

    assign bus.c_gnt   = w_c_gnt;
    assign bus.d_gnt   = w_d_gnt;
    assign bus.stallM  = reset && bus.c_req && !w_c_gnt;
    assign o_wait_cnt  = r_wait_cnt;

    // Drive the granted port onto the RAM; idle bus is all zeros.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_c_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.c_we;
            bus.mem_addr  = bus.c_addr[DMEM_POWER+1:2];
            bus.mem_wdata = bus.c_wdata;
        end else if (w_d_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr[DMEM_POWER+1:2];
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Starvation counter: counts refused DMA cycles, saturating, cleared on grant or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (!bus.d_req || w_d_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // FSM state register: last owner of the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: follows whichever port is granted, IDLE when none.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_c_gnt) begin
            w_state_nxt = S_CPU;
        end else if (w_d_gnt) begin
            w_state_nxt = S_DMA;
        end
    end

    // FSM output: owner encoding exported for debug visibility.
    always_comb begin
        o_state = 2'(r_state);
    end

    // ---- issue -> tag pipeline (MEM_LAT stages) ----
    // Read tags {valid, owner} travel alongside the RAM read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_vld_p0 <= '0;
            r_tag_dma_p0 <= '0;
        end else begin
            r_tag_vld_p0[0] <= w_rd_issue;
            r_tag_dma_p0[0] <= w_d_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld_p0[i] <= r_tag_vld_p0[i-1];
                r_tag_dma_p0[i] <= r_tag_dma_p0[i-1];
            end
        end
    end

    // ---- tag pipeline tail -> response routing ----
    assign w_c_rvalid   = r_tag_vld_p0[MEM_LAT-1] && !r_tag_dma_p0[MEM_LAT-1];
    assign w_d_rvalid   = r_tag_vld_p0[MEM_LAT-1] &&  r_tag_dma_p0[MEM_LAT-1];
    assign bus.c_rvalid = w_c_rvalid;
    assign bus.d_rvalid = w_d_rvalid;
    assign bus.c_rdata  = w_c_rvalid ? bus.mem_rdata : r_c_rdata;
    assign bus.d_rdata  = w_d_rvalid ? bus.mem_rdata : r_d_rdata;

    // Capture each port's last response so rdata holds between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_c_rvalid) begin
                r_c_rdata <= bus.mem_rdata;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, expected read responses queued
// at issue time and checked by an independent monitor on rvalid.
module tb_dmem_arbiter;
    localparam int DMEM_POWER = 18;
    localparam int MEM_LAT    = 2;
    localparam int MAX_WAIT   = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CPU  = 2'd1;
    localparam logic [1:0] S_DMA  = 2'd2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;
    logic [2:0] wait_cnt;
    int         nchk  = 0;
    int         nfail = 0;
    int         cyc   = 0;

    dmem_arbiter_if #(.DMEM_POWER(DMEM_POWER)) bus ();

    dmem_arbiter #(
        .DMEM_POWER(DMEM_POWER),
        .MEM_LAT   (MEM_LAT),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .o_state   (state),
        .o_wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with MEM_LAT read latency.
    logic [31:0] ram [0:(1<<DMEM_POWER)-1];
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_pipe[0] <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    typedef struct {
        bit          dma;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest expected response, on the expected cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.c_rvalid || bus.d_rvalid) begin
                chk("rvalid_onehot", 32'(bus.c_rvalid & bus.d_rvalid), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, bus.d_rvalid, bus.c_rvalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_owner", 32'(bus.d_rvalid), 32'(e.dma));
                    chk("rsp_data", e.dma ? bus.d_rdata : bus.c_rdata, e.data);
                    chk("rsp_cycle", 32'(cyc), 32'(e.at));
                end
            end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_missing_cycle", 32'(cyc), 32'(e.at - 1));
            end
        end
    end

    // One bus cycle: drive, check grant/issue at negedge, queue expected read data.
    task automatic step(input string nm,
                        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic ecg, input logic edg, input logic [31:0] ema,
                        input logic [31:0] erd, input bit rsp);
        logic ewe;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        ewe = ecg ? cw : (edg ? dw : 1'b0);
        @(negedge clk);
        chk({nm, ".c_gnt"},  32'(bus.c_gnt),  32'(ecg));
        chk({nm, ".d_gnt"},  32'(bus.d_gnt),  32'(edg));
        chk({nm, ".stallM"}, 32'(bus.stallM), 32'(cr & ~ecg));
        chk({nm, ".mem_en"}, 32'(bus.mem_en), 32'(ecg | edg));
        if (ecg || edg) begin
            chk({nm, ".mem_we"},   32'(bus.mem_we),   32'(ewe));
            chk({nm, ".mem_addr"}, 32'(bus.mem_addr), ema);
        end
        if (rsp && ((ecg && !cw) || (edg && !dw)))
            sbq.push_back('{dma: edg, data: erd, at: cyc + MEM_LAT});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic cpu_wr(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [31:0] ema);
        step(nm, 1, 1, a, d, 0, 0, 0, 0, 1, 0, ema, 0, 1);
    endtask

    task automatic cpu_rd(input string nm, input logic [31:0] a, input logic [31:0] ema, input logic [31:0] exp);
        step(nm, 1, 0, a, 0, 0, 0, 0, 0, 1, 0, ema, exp, 1);
    endtask

    task automatic dma_rd(input string nm, input logic [31:0] a, input logic [31:0] ema, input logic [31:0] exp);
        step(nm, 0, 0, 0, 0, 1, 0, a, 0, 0, 1, ema, exp, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        #1 reset = 1'b0;
        #2;
        chk("rst.c_gnt",    32'(bus.c_gnt),    0);
        chk("rst.d_gnt",    32'(bus.d_gnt),    0);
        chk("rst.mem_en",   32'(bus.mem_en),   0);
        chk("rst.c_rvalid", 32'(bus.c_rvalid), 0);
        chk("rst.c_rdata",  bus.c_rdata,       0);
        chk("rst.d_rdata",  bus.d_rdata,       0);
        chk("rst.state",    32'(state),        32'(S_IDLE));
        chk("rst.wait",     32'(wait_cnt),     0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Write then read back on the very next cycle.
        cpu_wr("t1.wr", 32'h10, 32'hDEADBEEF, 32'd4);
        chk("t1.state_cpu", 32'(state), 32'(S_CPU));
        cpu_rd("t1.rd", 32'h10, 32'd4, 32'hDEADBEEF);
        idle("t1.idle");

        // Starvation guard: CPU reads held, DMA writes held, DMA forced every 5th cycle.
        for (int i = 1; i <= 10; i++) begin
            logic cg;
            cg = (i % 5) != 0;
            step($sformatf("t2.c%0d", i), 1, 0, 32'h10, 0, 1, 1, 32'h200, 32'(i),
                 cg, !cg, cg ? 32'd4 : 32'h80, 32'hDEADBEEF, 1);
            chk($sformatf("t2.wait%0d", i), 32'(wait_cnt), 32'(i % 5));
            chk($sformatf("t2.state%0d", i), 32'(state), cg ? 32'(S_CPU) : 32'(S_DMA));
        end
        idle("t2.idle");

        // Interleaved reads, one per cycle, responses in issue order.
        cpu_wr("t3.w0", 32'h0, 32'h11111111, 32'd0);
        cpu_wr("t3.w4", 32'h4, 32'h22222222, 32'd1);
        cpu_wr("t3.w8", 32'h8, 32'h33333333, 32'd2);
        cpu_rd("t3.c0", 32'h0, 32'd0, 32'h11111111);
        dma_rd("t3.d4", 32'h4, 32'd1, 32'h22222222);
        chk("t3.state_dma", 32'(state), 32'(S_DMA));
        cpu_rd("t3.c8", 32'h8, 32'd2, 32'h33333333);
        dma_rd("t3.d0", 32'h0, 32'd0, 32'h11111111);
        step("t3.both", 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1, 0, 32'd1, 32'h22222222, 1);
        dma_rd("t3.d8", 32'h8, 32'd2, 32'h33333333);
        idle("t3.idle0");
        idle("t3.idle1");

        // Address wrap and ignored byte offset.
        cpu_wr("t4.wrap", 32'h4 + (32'd4 << DMEM_POWER), 32'h55, 32'd1);
        cpu_rd("t4.rd4", 32'h4, 32'd1, 32'h55);
        cpu_rd("t4.rd13", 32'h13, 32'd4, 32'hDEADBEEF);
        idle("t4.idle0");
        idle("t4.idle1");
        idle("t4.idle2");
        chk("t4.c_hold", bus.c_rdata, 32'hDEADBEEF);
        chk("t4.c_rvalid0", 32'(bus.c_rvalid), 0);
        chk("t4.d_hold", bus.d_rdata, 32'h33333333);

        // Reset with two reads in flight: responses must be dropped.
        step("t5.c0", 1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 0);
        step("t5.d4", 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, 32'd1, 0, 0);
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h8; bus.c_wdata = 32'hFFFFFFFF;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'hC; bus.d_wdata = 32'hFFFFFFFF;
        #2 reset = 1'b0;
        #1;
        chk("t5.c_gnt",    32'(bus.c_gnt),    0);
        chk("t5.d_gnt",    32'(bus.d_gnt),    0);
        chk("t5.stallM",   32'(bus.stallM),   0);
        chk("t5.mem_en",   32'(bus.mem_en),   0);
        chk("t5.mem_we",   32'(bus.mem_we),   0);
        chk("t5.mem_addr", 32'(bus.mem_addr), 0);
        chk("t5.c_rvalid", 32'(bus.c_rvalid), 0);
        chk("t5.d_rvalid", 32'(bus.d_rvalid), 0);
        chk("t5.c_rdata",  bus.c_rdata,       0);
        chk("t5.d_rdata",  bus.d_rdata,       0);
        chk("t5.state",    32'(state),        32'(S_IDLE));
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.c_req = 0; bus.d_req = 0;
        reset = 1'b1;

        // Quiet bus after reset: nothing issued, no stray responses.
        for (int i = 0; i < 5; i++) begin
            idle($sformatf("t6.idle%0d", i));
            chk($sformatf("t6.state%0d", i), 32'(state), 32'(S_IDLE));
        end

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
